// File: rtl/softmax_rd_req_ctrl_pkg.sv
// Shared constants, widths and FSM encoding for the softmax read-request sequencer.
package softmax_rd_req_ctrl_pkg;

   localparam int AXI_BURST_LEN  = 16;
   localparam int LOG2_BURST     = 4;
   localparam int ADDR_W         = 32;
   localparam int PIXEL_BYTES    = 64;
   localparam int CHG_W          = 8;
   localparam int H_W            = 12;
   localparam int W_W            = 12;
   localparam int SOFTMAX_PASSES = 3;
   localparam int PASS_W         = 2;
   // Enough bits to hold ceil(w_in/AXI_BURST_LEN) for the largest w_in.
   localparam int WB_W           = W_W - LOG2_BURST + 1;

   localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(AXI_BURST_LEN * PIXEL_BYTES);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   function automatic logic [WB_W-1:0] num_bursts(input logic [W_W-1:0] w_px);
      logic [W_W:0] w_sum;
      w_sum = {1'b0, w_px} + (W_W+1)'(AXI_BURST_LEN - 1);
      return w_sum[W_W:LOG2_BURST];
   endfunction

endpackage

// File: rtl/softmax_outstd_cnt.sv
// Saturating up/down count of bursts in flight, with full flag at MAX_OUTSTD.
module softmax_outstd_cnt #(
   parameter int MAX_OUTSTD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_inc,
   input  logic i_dec,
   output logic o_full,
   output logic o_empty
);

   localparam int CNT_W = $clog2(MAX_OUTSTD + 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_dec_ok;

   // A completion with nothing in flight is spurious and must not underflow.
   assign w_dec_ok = i_dec && (r_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_inc && !w_dec_ok) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end else if (!i_inc && w_dec_ok) begin
         r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign o_full  = (r_cnt >= CNT_W'(MAX_OUTSTD));
   assign o_empty = (r_cnt == '0);

endmodule

// File: rtl/softmax_rd_req_ctrl.sv
// Walks ch -> pass -> w-burst -> h and issues one read burst per step,
// capping bursts in flight; addresses come from stride accumulators.
module softmax_rd_req_ctrl
   import softmax_rd_req_ctrl_pkg::*;
#(
   parameter int MAX_OUTSTD = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_W-1:0]     base_addr,
   input  logic [ADDR_W-1:0]     surface_stride,
   input  logic [ADDR_W-1:0]     line_stride,
   input  logic [CHG_W-1:0]      ch_in_div_tout,
   input  logic [H_W-1:0]        h_in,
   input  logic [W_W-1:0]        w_in,
   output logic                  rd_req_vld,
   input  logic                  rd_req_rdy,
   output logic [ADDR_W-1:0]     rd_req_addr,
   output logic [LOG2_BURST-1:0] rd_req_len,
   input  logic                  burst_done,
   output logic                  busy,
   output logic                  done
);

   localparam logic [LOG2_BURST-1:0] FULL_LEN = LOG2_BURST'(AXI_BURST_LEN - 1);

   state_t r_state, w_state_next;

   logic [CHG_W-1:0]      r_ch, r_ch_last;
   logic [PASS_W-1:0]     r_pass;
   logic [WB_W-1:0]       r_wb, r_wb_last;
   logic [H_W-1:0]        r_h, r_h_last;
   logic [LOG2_BURST-1:0] r_last_len, r_len;
   logic [ADDR_W-1:0]     r_surf, r_line;
   logic [ADDR_W-1:0]     r_ch_addr, r_wb_addr, r_row_addr;
   logic                  r_busy, r_done;

   logic                  w_accept, w_full, w_empty;
   logic                  w_start_job, w_done_next;
   logic                  w_ch_wrap, w_pass_wrap, w_wb_wrap, w_h_wrap, w_last_req;
   logic [WB_W-1:0]       w_start_wb_last, w_wb_inc;
   logic [LOG2_BURST-1:0] w_start_last_len;
   logic [ADDR_W-1:0]     w_next_wb_addr, w_next_row_addr;

   softmax_outstd_cnt #(
      .MAX_OUTSTD (MAX_OUTSTD)
   ) u_outstd_cnt (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_inc   (w_accept),
      .i_dec   (burst_done),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // The cap can only rise through an accept, so a pending request never loses vld.
   assign rd_req_vld  = (r_state == ST_ISSUE) && !w_full;
   assign w_accept    = rd_req_vld && rd_req_rdy;
   assign rd_req_addr = r_ch_addr;
   assign rd_req_len  = r_len;
   assign busy        = r_busy;
   assign done        = r_done;

   assign w_ch_wrap   = (r_ch == r_ch_last);
   assign w_pass_wrap = (r_pass == PASS_W'(SOFTMAX_PASSES - 1));
   assign w_wb_wrap   = (r_wb == r_wb_last);
   assign w_h_wrap    = (r_h == r_h_last);
   assign w_last_req  = w_ch_wrap && w_pass_wrap && w_wb_wrap && w_h_wrap;

   assign w_start_wb_last  = num_bursts(w_in) - WB_W'(1);
   assign w_start_last_len = w_in[LOG2_BURST-1:0] - LOG2_BURST'(1);
   assign w_wb_inc         = r_wb + WB_W'(1);
   assign w_next_wb_addr   = r_wb_addr + BURST_BYTES;
   assign w_next_row_addr  = r_row_addr + r_line;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_start_job  = 1'b0;
      w_done_next  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_state_next = ST_ISSUE;
               w_start_job  = 1'b1;
            end
         end
         ST_ISSUE: begin
            if (w_accept && w_last_req) begin
               w_state_next = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (w_empty) begin
               w_state_next = ST_IDLE;
               w_done_next  = 1'b1;
            end
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ch       <= '0;
         r_ch_last  <= '0;
         r_pass     <= '0;
         r_wb       <= '0;
         r_wb_last  <= '0;
         r_h        <= '0;
         r_h_last   <= '0;
         r_last_len <= '0;
         r_len      <= '0;
         r_surf     <= '0;
         r_line     <= '0;
         r_ch_addr  <= '0;
         r_wb_addr  <= '0;
         r_row_addr <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         r_busy <= (w_state_next != ST_IDLE);
         r_done <= w_done_next;
         if (w_start_job) begin
            r_ch       <= '0;
            r_pass     <= '0;
            r_wb       <= '0;
            r_h        <= '0;
            r_ch_last  <= ch_in_div_tout - CHG_W'(1);
            r_h_last   <= h_in - H_W'(1);
            r_wb_last  <= w_start_wb_last;
            r_last_len <= w_start_last_len;
            r_len      <= (w_start_wb_last == '0) ? w_start_last_len : FULL_LEN;
            r_surf     <= surface_stride;
            r_line     <= line_stride;
            r_ch_addr  <= base_addr;
            r_wb_addr  <= base_addr;
            r_row_addr <= base_addr;
         end else if (w_accept) begin
            if (!w_ch_wrap) begin
               r_ch      <= r_ch + CHG_W'(1);
               r_ch_addr <= r_ch_addr + r_surf;
            end else begin
               r_ch <= '0;
               if (!w_pass_wrap) begin
                  r_pass    <= r_pass + PASS_W'(1);
                  r_ch_addr <= r_wb_addr;
               end else begin
                  r_pass <= '0;
                  if (!w_wb_wrap) begin
                     r_wb      <= w_wb_inc;
                     r_wb_addr <= w_next_wb_addr;
                     r_ch_addr <= w_next_wb_addr;
                     r_len     <= (w_wb_inc == r_wb_last) ? r_last_len : FULL_LEN;
                  end else begin
                     r_wb  <= '0;
                     r_len <= (r_wb_last == '0) ? r_last_len : FULL_LEN;
                     if (!w_h_wrap) begin
                        r_h        <= r_h + H_W'(1);
                        r_row_addr <= w_next_row_addr;
                        r_wb_addr  <= w_next_row_addr;
                        r_ch_addr  <= w_next_row_addr;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_softmax_rd_req_ctrl.sv
// Self-checking bench: table of jobs, hand sequences for handshake/cap/reset, and random jobs vs. a loop-nest model.
module tb_softmax_rd_req_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [31:0] base_addr, surface_stride, line_stride;
   logic [7:0]  ch_in_div_tout;
   logic [11:0] h_in, w_in;
   logic        rd_req_vld, rd_req_rdy;
   logic [31:0] rd_req_addr;
   logic [3:0]  rd_req_len;
   logic        burst_done, busy, done;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  len;
   } req_t;

   typedef struct {
      int          w, h, c;
      logic [31:0] base, surf, line;
      int          nreq;
      int          last_len;
      int          probe;
      logic [31:0] probe_addr;
   } vec_t;

   req_t exp_q[$];
   req_t acc_q[$];
   int   due_q[$];

   softmax_rd_req_ctrl #(.MAX_OUTSTD(4)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .base_addr      (base_addr),
      .surface_stride (surface_stride),
      .line_stride    (line_stride),
      .ch_in_div_tout (ch_in_div_tout),
      .h_in           (h_in),
      .w_in           (w_in),
      .rd_req_vld     (rd_req_vld),
      .rd_req_rdy     (rd_req_rdy),
      .rd_req_addr    (rd_req_addr),
      .rd_req_len     (rd_req_len),
      .burst_done     (burst_done),
      .busy           (busy),
      .done           (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Expected request stream straight from the loop nest and address formula.
   task automatic build_model(input int w, input int h, input int c,
                              input logic [31:0] base, input logic [31:0] surf, input logic [31:0] line);
      int   nwb;
      req_t e;
      exp_q.delete();
      nwb = (w + 15) / 16;
      for (int hh = 0; hh < h; hh++)
         for (int wb = 0; wb < nwb; wb++)
            for (int p = 0; p < 3; p++)
               for (int cc = 0; cc < c; cc++) begin
                  e.addr = base + 32'(cc) * surf + 32'(hh) * line + 32'(wb) * 32'd1024;
                  if (wb == nwb - 1) e.len = (w % 16 == 0) ? 4'd15 : 4'((w % 16) - 1);
                  else               e.len = 4'd15;
                  exp_q.push_back(e);
               end
   endtask

   task automatic start_job(input int w, input int h, input int c,
                            input logic [31:0] base, input logic [31:0] surf, input logic [31:0] line);
      w_in           = 12'(w);
      h_in           = 12'(h);
      ch_in_div_tout = 8'(c);
      base_addr      = base;
      surface_stride = surf;
      line_stride    = line;
      start          = 1'b1;
      step();
      start          = 1'b0;
      // CSRs must be ignored once the job has started.
      base_addr      = $urandom;
      surface_stride = $urandom;
      line_stride    = $urandom;
      w_in           = 12'($urandom);
      h_in           = 12'($urandom);
      ch_in_div_tout = 8'($urandom);
   endtask

   task automatic run_job(input int w, input int h, input int c,
                          input logic [31:0] base, input logic [31:0] surf, input logic [31:0] line,
                          input int rdy_pct, input int dmin, input int dmax);
      int   cyc, out_cnt, last_due, nexp, dly;
      bit   done_seen, prev_stall, acc;
      req_t prev, e;
      build_model(w, h, c, base, surf, line);
      nexp = exp_q.size();
      acc_q.delete();
      due_q.delete();
      out_cnt = 0; last_due = 0; cyc = 0; done_seen = 0; prev_stall = 0;
      prev = '0;
      rd_req_rdy = 1'b0;
      burst_done = 1'b0;
      start_job(w, h, c, base, surf, line);
      while (!done_seen && cyc < 20000) begin
         rd_req_rdy = ($urandom_range(99) < 32'(rdy_pct));
         burst_done = 1'b0;
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            burst_done = 1'b1;
            void'(due_q.pop_front());
         end
         #1;
         if (done) begin
            done_seen = 1;
            chk("done_all_req", 64'(exp_q.size()), 64'(0));
            chk("done_outstd", 64'(out_cnt), 64'(0));
            chk("done_busy", 64'(busy), 64'(0));
         end else begin
            chk("busy", 64'(busy), 64'(1));
            chk("vld_rule", 64'(rd_req_vld), 64'(exp_q.size() > 0 && out_cnt < 4));
         end
         if (prev_stall) begin
            chk("stable_addr", 64'(rd_req_addr), 64'(prev.addr));
            chk("stable_len", 64'(rd_req_len), 64'(prev.len));
         end
         acc = rd_req_vld && rd_req_rdy;
         if (acc) begin
            if (exp_q.size() == 0) chk("req_count", 64'(acc_q.size() + 1), 64'(nexp));
            else begin
               e = exp_q.pop_front();
               chk("req_addr", 64'(rd_req_addr), 64'(e.addr));
               chk("req_len", 64'(rd_req_len), 64'(e.len));
            end
            acc_q.push_back({rd_req_addr, rd_req_len});
            dly = int'($urandom_range(dmax, dmin));
            last_due = (cyc + dly > last_due + 1) ? cyc + dly : last_due + 1;
            due_q.push_back(last_due);
         end
         prev_stall = rd_req_vld && !rd_req_rdy;
         prev = {rd_req_addr, rd_req_len};
         out_cnt = out_cnt + int'(acc) - int'(burst_done);
         step();
         cyc++;
      end
      rd_req_rdy = 1'b0;
      burst_done = 1'b0;
      chk("done_seen", 64'(done_seen), 64'(1));
      chk("done_single", 64'(done), 64'(0));
      $display("job w=%0d h=%0d ch=%0d base=0x%08h: %0d requests, %0d cycles", w, h, c, base, acc_q.size(), cyc);
   endtask

   vec_t vecs[5];

   initial begin
      int nacc;
      vecs[0] = '{40,   1, 2, 32'h0000_1000, 32'h0001_0000, 32'h0000_0A00, 18,  7,   7, 32'h0001_1400};
      vecs[1] = '{16,   2, 1, 32'h0000_2000, 32'h0000_0100, 32'h0000_0800, 6,   15,  3, 32'h0000_2800};
      vecs[2] = '{1,    1, 1, 32'h0000_3000, 32'h0000_0100, 32'h0000_0100, 3,   0,   2, 32'h0000_3000};
      vecs[3] = '{17,   2, 3, 32'hFFFF_FC00, 32'h0000_0100, 32'h0000_1000, 36,  0,  29, 32'h0000_1200};
      vecs[4] = '{4095, 1, 1, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 768, 14, 767, 32'h0003_FC00};

      rst_n = 1'b0; start = 1'b0; rd_req_rdy = 1'b0; burst_done = 1'b0;
      base_addr = '0; surface_stride = '0; line_stride = '0;
      ch_in_div_tout = 8'd1; h_in = 12'd1; w_in = 12'd1;
      step(); step();
      chk("rst_vld", 64'(rd_req_vld), 64'(0));
      chk("rst_addr", 64'(rd_req_addr), 64'(0));
      chk("rst_len", 64'(rd_req_len), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      rst_n = 1'b1;
      step();

      // Backpressure: vld/addr/len hold while rdy is low, then exactly one accept.
      start_job(40, 1, 2, 32'h1000, 32'h10000, 32'hA00);
      for (int i = 0; i < 5; i++) begin
         chk("bp_vld", 64'(rd_req_vld), 64'(1));
         chk("bp_addr", 64'(rd_req_addr), 64'(32'h1000));
         chk("bp_len", 64'(rd_req_len), 64'(15));
         step();
      end
      rd_req_rdy = 1'b1;
      step();
      rd_req_rdy = 1'b0;
      #1;
      chk("bp_one_accept", 64'(rd_req_addr), 64'(32'h11000));
      step();
      chk("bp_hold_after", 64'(rd_req_addr), 64'(32'h11000));
      rst_n = 1'b0;
      #1;
      chk("bp_rst_vld", 64'(rd_req_vld), 64'(0));
      step();
      rst_n = 1'b1;
      step();

      // Outstanding cap, start-while-busy, then reset mid-ISSUE.
      start_job(40, 1, 2, 32'h4000, 32'h100, 32'hA00);
      rd_req_rdy = 1'b1;
      nacc = 0;
      for (int i = 0; i < 8; i++) begin
         start = (i == 2);
         base_addr = 32'h9990_0000;
         #1;
         if (rd_req_vld && rd_req_rdy) nacc++;
         step();
      end
      start = 1'b0;
      chk("cap_accepts", 64'(nacc), 64'(4));
      chk("cap_vld_low", 64'(rd_req_vld), 64'(0));
      burst_done = 1'b1;
      #1;
      chk("cap_vld_at_bd", 64'(rd_req_vld), 64'(0));
      step();
      #1;
      chk("cap_vld_after_bd", 64'(rd_req_vld), 64'(1));
      step();
      burst_done = 1'b0;
      #1;
      chk("cap_simul_hold", 64'(rd_req_vld), 64'(1));
      step();
      chk("cap_full_again", 64'(rd_req_vld), 64'(0));
      chk("busy_start_ignored", 64'(rd_req_addr), 64'(32'h4400));
      chk("cap_len", 64'(rd_req_len), 64'(15));
      rd_req_rdy = 1'b0;
      burst_done = 1'b1;
      step();
      burst_done = 1'b0;
      chk("pre_rst_vld", 64'(rd_req_vld), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("midrst_vld", 64'(rd_req_vld), 64'(0));
      chk("midrst_busy", 64'(busy), 64'(0));
      chk("midrst_addr", 64'(rd_req_addr), 64'(0));
      for (int i = 0; i < 2; i++) begin
         step();
         chk("midrst_no_done", 64'(done), 64'(0));
      end
      rst_n = 1'b1;
      step();

      // Table-driven jobs with rdy=1 and burst_done 4 cycles after each accept.
      for (int v = 0; v < 5; v++) begin
         run_job(vecs[v].w, vecs[v].h, vecs[v].c, vecs[v].base, vecs[v].surf, vecs[v].line, 100, 4, 4);
         chk("tbl_nreq", 64'(acc_q.size()), 64'(vecs[v].nreq));
         if (acc_q.size() > vecs[v].probe) begin
            chk("tbl_probe_addr", 64'(acc_q[vecs[v].probe].addr), 64'(vecs[v].probe_addr));
            chk("tbl_last_len", 64'(acc_q[acc_q.size()-1].len), 64'(vecs[v].last_len));
         end
         step();
      end

      // Randomized jobs, handshake stalls and response latencies.
      for (int r = 0; r < 8; r++) begin
         run_job(int'($urandom_range(40, 1)), int'($urandom_range(3, 1)), int'($urandom_range(3, 1)),
                 $urandom, $urandom, $urandom,
                 int'($urandom_range(100, 30)), 1, int'($urandom_range(9, 1)));
         step();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
